// File: rtl/mbist_pkg.sv
// Purpose : shared types and March C- element tables for the MBIST controller.
// Latency : n/a (types, constants and tables only).
// Backpressure: n/a.
package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    EL_0,
    EL_1,
    EL_2,
    EL_3,
    EL_4,
    EL_5
  } march_elem_e;

  typedef logic [2:0] elem_idx_t;

  localparam int        MARCH_ELEMS = 6;
  localparam elem_idx_t LAST_ELEM   = elem_idx_t'(EL_5);

  // Per-element tables, bit n describes element n. They are padded to 8 bits so
  // any 3-bit element index lands on a defined entry.
  //   E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)  E3 dn(r0,w1)  E4 dn(r1,w0)  E5 up(r0)
  localparam logic [7:0] ELEM_DOWN = 8'b0001_1000; // walks DEPTH-1..0
  localparam logic [7:0] ELEM_TWO  = 8'b0001_1110; // two ops per address
  localparam logic [7:0] OP0_RD    = 8'b0011_1110; // first op is a read
  localparam logic [7:0] OP0_ONE   = 8'b0001_0100; // first op uses ~bg
  localparam logic [7:0] OP1_ONE   = 8'b0000_1010; // second op (always a write) uses ~bg

endpackage

// File: rtl/mbist_addr_counter.sv
// Purpose : loadable up/down address counter with terminal-count flag.
// Latency : count/load visible one cycle after the request; cout is combinational.
// Backpressure: none, advances whenever en is high.
// Ports   : load (preset to 0 when up, all-ones when down, and latch direction),
//           up (direction to use from the next load), en (step), cnt, cout.
module mbist_addr_counter #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              up,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt,
  output logic              cout
);

  // Direction is latched at load so that cout (which feeds the caller's load
  // decision) never depends on the direction requested for the next walk.
  logic dir_up;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      dir_up <= 1'b1;
    end else if (load) begin
      cnt    <= up ? '0 : '1;
      dir_up <= up;
    end else if (en) begin
      cnt <= dir_up ? cnt + 1'b1 : cnt - 1'b1;
    end
  end

  assign cout = dir_up ? (cnt == '1) : (cnt == '0);

endmodule

// File: rtl/mbist_march_ctrl.sv
// Purpose : March C- memory BIST sequencer with first-failure capture.
// Latency : one memory op per RUN cycle, read compared one cycle later; 10*DEPTH+1 busy cycles.
// Backpressure: none; the memory must accept an op every cycle and return read data one cycle later.
// Ports   : start/bg/stop_on_fail request a test; mem_* drive the memory while NbarT=1;
//           busy/done/fail report status; fail_addr/fail_elem/fail_data hold the first miscompare.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bg,
  input  logic              stop_on_fail,
  output logic              NbarT,
  output logic              ld,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data
);

  state_e            state_q, state_d;
  elem_idx_t         elem_q, next_elem;
  logic              op_q;          // 0 = first op at this address, 1 = second
  logic [DATA_W-1:0] bg_q;
  logic [DATA_W-1:0] exp_q;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  elem_idx_t         cmp_elem_q;

  logic [ADDR_W-1:0] cnt;
  logic              cout;
  logic              cnt_load, cnt_up, cnt_en;

  logic              accept, mismatch, kill, run_step;
  logic              op_rd, op_one, last_op, elem_done;
  logic [DATA_W-1:0] op_dat;

  assign accept    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
  assign mismatch  = rd_pend_q && (mem_rdata != exp_q);
  // An abort suppresses the op of the compare cycle itself, so nothing touches
  // the memory after a miscompare is seen.
  assign kill      = stop_on_fail && mismatch;
  assign run_step  = (state_q == ST_RUN) && !kill;

  assign op_rd     = !op_q && OP0_RD[elem_q];
  assign op_one    = op_q ? OP1_ONE[elem_q] : OP0_ONE[elem_q];
  assign op_dat    = op_one ? ~bg_q : bg_q;
  assign last_op   = !ELEM_TWO[elem_q] || op_q;
  assign elem_done = run_step && last_op && cout;
  assign next_elem = elem_q + 3'd1;

  assign cnt_load  = accept || (elem_done && (elem_q != LAST_ELEM));
  assign cnt_en    = run_step && last_op && !cout;
  assign cnt_up    = accept || !ELEM_DOWN[next_elem];

  mbist_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .up    (cnt_up),
    .en    (cnt_en),
    .cnt   (cnt),
    .cout  (cout)
  );

  always_comb begin
    state_d   = state_q;
    NbarT     = 1'b0;
    ld        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        ld = 1'b1;
        if (start) state_d = ST_RUN;
      end
      ST_DONE: begin
        ld   = 1'b1;
        done = 1'b1;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        NbarT = 1'b1;
        busy  = 1'b1;
        if (kill) begin
          state_d = ST_DONE;
        end else begin
          mem_we    = !op_rd;
          mem_re    = op_rd;
          mem_addr  = cnt;
          mem_wdata = op_dat;
          if (elem_done && (elem_q == LAST_ELEM)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Holds the compare of the last E5 read.
        NbarT   = 1'b1;
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      elem_q     <= '0;
      op_q       <= 1'b0;
      bg_q       <= '0;
      exp_q      <= '0;
      rd_pend_q  <= 1'b0;
      cmp_addr_q <= '0;
      cmp_elem_q <= '0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_data  <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= mem_re;
      if (mem_re) begin
        exp_q      <= op_dat;
        cmp_addr_q <= cnt;
        cmp_elem_q <= elem_q;
      end
      if (accept) begin
        bg_q      <= bg;
        elem_q    <= '0;
        op_q      <= 1'b0;
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_data <= '0;
      end else begin
        if (run_step) op_q <= !last_op;
        if (elem_done && (elem_q != LAST_ELEM)) elem_q <= next_elem;
        if (mismatch && !fail) begin
          fail      <= 1'b1;
          fail_addr <= cmp_addr_q;
          fail_elem <= cmp_elem_q;
          fail_data <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: ADDR_W=2, DATA_W=8, memory with optional bit-0
// stuck-at-1 at address 2.
module tb_mbist_march_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] bg = '0;
  logic          stop_on_fail = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          NbarT, ld, mem_we, mem_re, busy, done, fail;
  logic [AW-1:0] mem_addr, fail_addr;
  logic [DW-1:0] mem_wdata, fail_data;
  logic [2:0]    fail_elem;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bg           (bg),
    .stop_on_fail (stop_on_fail),
    .NbarT        (NbarT),
    .ld           (ld),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_addr    (fail_addr),
    .fail_elem    (fail_elem),
    .fail_data    (fail_data)
  );

  // Memory: one-cycle read latency, optional stuck-at-1 on bit 0 of address 2.
  logic [DW-1:0] mem [DEPTH];
  bit            fault_on = 1'b0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr] | ((fault_on && mem_addr == 2'd2) ? 8'h01 : 8'h00);
  end

  typedef struct {
    bit            busy;
    bit            we;
    bit            re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            fail;
  } exp_t;

  exp_t          exp_q[$];
  bit            exp_fail;
  logic [AW-1:0] exp_fa;
  logic [2:0]    exp_fe;
  logic [DW-1:0] exp_fd;
  int            checks = 0;
  int            failures = 0;
  int            busy_cnt = 0;
  logic [AW-1:0] tr_addr [64];
  bit            tr_we [64];
  bit            tr_re [64];
  logic [DW-1:0] tr_wd [64];
  logic [AW-1:0] e3a [8];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, want);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, 32'({NbarT, ld, busy, done, fail, mem_we, mem_re}), 32'(7'b0100000));
    check({tag, "_bus"}, 32'({mem_addr, mem_wdata}), 32'd0);
    check({tag, "_cap"}, 32'({fail_addr, fail_elem, fail_data}), 32'd0);
  endtask

  // Expected per-cycle behaviour of one test, from the March C- definition.
  task automatic build(input logic [DW-1:0] b, input bit flt, input bit sof);
    logic [DW-1:0] mm [DEPTH];
    int nops [6] = '{1, 2, 2, 2, 2, 1};
    bit dn   [6] = '{0, 0, 0, 1, 1, 0};
    bit rd0  [6] = '{0, 1, 1, 1, 1, 1};
    bit v0   [6] = '{0, 0, 1, 0, 1, 0};
    bit v1   [6] = '{0, 1, 0, 1, 0, 0};
    int fail_at;
    bit stop;
    int a;
    bit rd, v;
    logic [DW-1:0] got;
    exp_t e;
    exp_q.delete();
    fail_at = -1; stop = 0;
    exp_fail = 0; exp_fa = '0; exp_fe = '0; exp_fd = '0;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    for (int el = 0; el < 6; el++)
      for (int k = 0; k < DEPTH; k++)
        for (int o = 0; o < nops[el]; o++)
          if (!stop) begin
            a = dn[el] ? DEPTH - 1 - k : k;
            rd = (o == 0) && rd0[el];
            v = (o == 0) ? v0[el] : v1[el];
            e.busy = 1; e.we = !rd; e.re = rd; e.fail = 0;
            e.addr = AW'(a);
            e.wdata = v ? ~b : b;
            if (rd) begin
              got = mm[a] | ((flt && a == 2) ? 8'h01 : 8'h00);
              if (got != e.wdata && !exp_fail) begin
                exp_fail = 1; fail_at = exp_q.size();
                exp_fa = AW'(a); exp_fe = 3'(el); exp_fd = got;
                if (sof) stop = 1;
              end
            end else begin
              mm[a] = e.wdata;
            end
            exp_q.push_back(e);
          end
    // Compare-only cycle: FLUSH, or the abort cycle.
    e.busy = 1; e.we = 0; e.re = 0; e.addr = '0; e.wdata = '0; e.fail = 0;
    exp_q.push_back(e);
    if (exp_fail)
      for (int i = fail_at + 2; i < exp_q.size(); i++) exp_q[i].fail = 1;
  endtask

  task automatic run(input logic [DW-1:0] b, input bit flt, input bit sof,
                     input bit hold, input bit pre, input int abort_at);
    exp_t e;
    logic [6:0] gc, wc;
    bg = b; fault_on = flt; stop_on_fail = sof;
    build(b, flt, sof);
    busy_cnt = 0;
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("abort");
        return;
      end
      e = exp_q[i];
      if (busy) busy_cnt++;
      tr_addr[i] = mem_addr; tr_we[i] = mem_we; tr_re[i] = mem_re; tr_wd[i] = mem_wdata;
      gc = {busy, NbarT, ld, done, mem_we, mem_re, fail};
      wc = {e.busy, e.busy, !e.busy, 1'b0, e.we, e.re, e.fail};
      check($sformatf("cyc%0d_ctl", i), 32'(gc), 32'(wc));
      if (e.we || e.re) check($sformatf("cyc%0d_addr", i), 32'(mem_addr), 32'(e.addr));
      if (e.we) check($sformatf("cyc%0d_wdata", i), 32'(mem_wdata), 32'(e.wdata));
    end
    @(negedge clk);
    check("end_ctl", 32'({busy, NbarT, ld, done, fail}), 32'({1'b0, 1'b0, 1'b1, 1'b1, exp_fail}));
    if (exp_fail)
      check("end_cap", 32'({fail_addr, fail_elem, fail_data}), 32'({exp_fa, exp_fe, exp_fd}));
  endtask

  initial begin
    e3a = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle");

    // Fault-free, bg=00.
    run(8'h00, 0, 0, 0, 0, -1);
    check("clean_busy", 32'(busy_cnt), 32'd41);

    // Fault-free, bg=A5: E3 walk and E1 write data.
    run(8'hA5, 0, 0, 0, 0, -1);
    check("a5_busy", 32'(busy_cnt), 32'd41);
    check("a5_e0_wd", 32'(tr_wd[0]), 32'h0A5);
    check("a5_e1_wd", 32'(tr_wd[5]), 32'h05A);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("e3_addr%0d", j), 32'(tr_addr[20 + j]), 32'(e3a[j]));
      check($sformatf("e3_re%0d", j), 32'(tr_re[20 + j]), 32'((j % 2) == 0));
      check($sformatf("e3_we%0d", j), 32'(tr_we[20 + j]), 32'((j % 2) == 1));
    end

    // Stuck-at fault, run to completion.
    run(8'h00, 1, 0, 0, 0, -1);
    check("flt_busy", 32'(busy_cnt), 32'd41);
    check("flt_addr", 32'(fail_addr), 32'd2);
    check("flt_elem", 32'(fail_elem), 32'd1);
    check("flt_data", 32'(fail_data), 32'h01);

    // Stuck-at fault, abort on first miscompare.
    run(8'h00, 1, 1, 0, 0, -1);
    check("sof_busy", 32'(busy_cnt), 32'd10);
    check("sof_kill_ops", 32'({tr_we[9], tr_re[9]}), 32'd0);
    check("sof_cap", 32'({fail_addr, fail_elem, fail_data}), 32'({2'd2, 3'd1, 8'h01}));

    // Reset mid-E2 (fail already set), then a clean full run.
    run(8'h00, 1, 0, 0, 0, 15);
    run(8'h00, 0, 0, 0, 0, -1);
    check("post_rst_busy", 32'(busy_cnt), 32'd41);

    // start held through RUN, then restart straight out of DONE.
    run(8'h3C, 1, 0, 1, 0, -1);
    check("hold_busy", 32'(busy_cnt), 32'd41);
    run(8'h3C, 0, 0, 0, 1, -1);
    check("restart_busy", 32'(busy_cnt), 32'd41);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width; DEPTH = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 8, memory word width.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  test request, sampled only in IDLE or DONE.
REQ-006 bg  input  DATA_W  data background, latched when start is accepted.
REQ-007 stop_on_fail  input  1  mode: 1 = abort to DONE on first miscompare, 0 = run to completion.
REQ-008 NbarT  output  1  memory mux select, 1 = BIST owns memory.
REQ-009 ld  output  1  idle/load indicator, 1 in IDLE and DONE.
REQ-010 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_we  output  1; mem_re  output  1.
REQ-011 mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_re.
REQ-012 busy  output  1; done  output  1; fail  output  1.
REQ-013 fail_addr  output  ADDR_W; fail_elem  output  3; fail_data  output  DATA_W  first-failure capture.

Function
REQ-014 States: IDLE, RUN, FLUSH, DONE.
REQ-015 IDLE/DONE with start=1 -> RUN next cycle; bg latched; fail, fail_* cleared; address and element reset.
REQ-016 RUN executes March C- elements 0..5: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-017 "0" = latched bg, "1" = ~bg; one operation per RUN cycle; address advances after the last op of an element at that address.
REQ-018 Up elements walk 0..DEPTH-1, down elements walk DEPTH-1..0; element advance at terminal address, with the next element starting at its own first address.
REQ-019 Total RUN length = 10*DEPTH cycles; then FLUSH for 1 cycle (final compare); then DONE.
REQ-020 mem_addr, mem_wdata, mem_we, mem_re are driven in the same cycle as the op; mem_we and mem_re are never both 1; both are 0 outside RUN.
REQ-021 Compare: cycle after each read, mem_rdata vs expected; mismatch sets sticky fail.
REQ-022 First mismatch only: capture fail_addr, fail_elem, fail_data (=mem_rdata); later mismatches do not overwrite.
REQ-023 stop_on_fail=1 and mismatch -> DONE next cycle, without further memory ops.
REQ-024 NbarT=1 and busy=1 in RUN and FLUSH; ld=1 and NbarT=0 in IDLE and DONE.
REQ-025 done=1 only in DONE; held until a new start is accepted.
REQ-026 start in RUN/FLUSH is ignored.
REQ-027 DEPTH=2 is legal, and ADDR_W=1 is the minimum.

Reset
REQ-028 rst_n=0 at a clock edge -> IDLE regardless of state, including mid-RUN.
REQ-029 Reset values: NbarT=0, ld=1, busy=0, done=0, fail=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, fail_addr=0, fail_elem=0, fail_data=0.
REQ-030 No reset-pending memory op: a read issued in the cycle before reset is not compared.

Structure
REQ-031 Package mbist_pkg holds the state enum, the march element enum/index type, MARCH_ELEMS=6, and per-element direction/op tables.
REQ-032 Sub-module mbist_addr_counter (ADDR_W): load, up/down, enable, terminal-count output cout; one instance.

Verification
REQ-033 ADDR_W=2, bg=8'h00, fault-free memory model; start pulse -> busy for 41 cycles (40 RUN + 1 FLUSH), then done=1, fail=0, ld=1, NbarT=0.
REQ-034 Bit 0 stuck-at-1 at addr 2, stop_on_fail=0 -> fail=1, fail_addr=2, fail_elem=1, fail_data=8'h01, done after full 41 cycles.
REQ-035 Same fault, stop_on_fail=1 -> DONE entered the cycle after the E1 addr-2 compare; no mem_we after the miscompare.
REQ-036 Monitor on E3 -> mem_addr sequence 3,3,2,2,1,1,0,0 with mem_re/mem_we alternating; bg=8'hA5 -> E1 writes 8'h5A.
REQ-037 rst_n=0 for 1 cycle mid-E2 -> next cycle IDLE with all REQ-029 values; new start runs full 41 cycles.
REQ-038 start held high through RUN -> no restart; in DONE with start=1 -> RUN next cycle, done=0, fail cleared.
